// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Sticky framing/overrun flags and a registered interrupt summarise pending work.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    input  logic [DIV_W-1:0]            clks_per_bit,
    input  logic                        rd_en,
    input  logic                        err_clr,
    output logic [7:0]                  rd_data,
    output logic                        rx_empty,
    output logic                        rx_full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           r_state, w_stateNext;
    logic             r_rxMeta, r_rxS;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wrPtr, r_rdPtr;
    logic             r_frameErr, r_overrun, r_irq;

    logic [DIV_W-1:0] w_divIn;
    logic             w_halfTick, w_bitTick;
    logic             w_startFrame, w_sampleBit, w_stopOk, w_stopBad;
    logic             w_empty, w_full, w_pop, w_push, w_dropByte;
    logic [AW:0]      w_count;

    assign w_divIn    = (clks_per_bit < DIV_W'(4)) ? DIV_W'(4) : clks_per_bit;
    assign w_halfTick = (r_cnt == (r_div >> 1) - DIV_W'(1));
    assign w_bitTick  = (r_cnt == r_div - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxS    <= r_rxMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:      if (!r_rxS) w_stateNext = START;
            START:     if (w_halfTick) w_stateNext = r_rxS ? IDLE : DATA;
            DATA:      if (w_bitTick && r_bitIdx == 3'd7) w_stateNext = STOP;
            STOP:      if (w_bitTick) w_stateNext = r_rxS ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (r_rxS) w_stateNext = IDLE;
            default:   w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_startFrame = (r_state == IDLE) && !r_rxS;
        w_sampleBit  = (r_state == DATA) && w_bitTick;
        w_stopOk     = (r_state == STOP) && w_bitTick && r_rxS;
        w_stopBad    = (r_state == STOP) && w_bitTick && !r_rxS;
    end

    // Bit timing counter restarts on every state change and after each full-bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= DIV_W'(4);
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            if (w_startFrame) r_div <= w_divIn;
            if (w_stateNext != r_state)
                r_cnt <= '0;
            else if (r_state == DATA || r_state == STOP)
                r_cnt <= w_bitTick ? '0 : r_cnt + DIV_W'(1);
            else if (r_state == START)
                r_cnt <= r_cnt + DIV_W'(1);
            else
                r_cnt <= '0;
            if (r_state == START && w_stateNext == DATA) r_bitIdx <= '0;
            else if (w_sampleBit)                        r_bitIdx <= r_bitIdx + 3'd1;
            if (w_sampleBit) r_shift <= {r_rxS, r_shift[7:1]};
        end
    end

    assign w_count    = r_wrPtr - r_rdPtr;
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop      = rd_en && !w_empty;
    assign w_push     = w_stopOk && (!w_full || w_pop);
    assign w_dropByte = w_stopOk && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // A set event in the same cycle as err_clr keeps the flag raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_stopBad)    r_frameErr <= 1'b1;
            else if (err_clr) r_frameErr <= 1'b0;
            if (w_dropByte)   r_overrun  <= 1'b1;
            else if (err_clr) r_overrun  <= 1'b0;
            r_irq <= !w_empty || r_frameErr || r_overrun;
        end
    end

    assign rd_data   = w_empty ? 8'h00 : r_mem[r_rdPtr[AW-1:0]];
    assign rx_empty  = w_empty;
    assign rx_full   = w_full;
    assign count     = w_count;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;
    assign irq       = r_irq;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a UART transmitter drives directed frames, and a scoreboard
// queue of expected bytes is checked by a monitor whenever the bench pops the FIFO.
module tb_uart_rx_fifo;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;
    localparam int BIT        = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rx;
    logic [DIV_W-1:0] clks_per_bit;
    logic             rd_en;
    logic             err_clr;
    logic [7:0]       rd_data;
    logic             rx_empty;
    logic             rx_full;
    logic [3:0]       count;
    logic             frame_err;
    logic             overrun;
    logic             irq;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] expQ [$];

    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .clks_per_bit(clks_per_bit),
        .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data), .rx_empty(rx_empty),
        .rx_full(rx_full), .count(count), .frame_err(frame_err), .overrun(overrun),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sends one 8N1 frame at BIT clocks per bit, starting at a negedge; the line is
    // left at the stop-bit level. popAtPush raises rd_en exactly in the stop-sample cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic popAtPush);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stopBit;
        if (popAtPush) begin
            repeat (10) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (BIT) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulseErrClr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
    endtask

    // Monitor: every cycle in which a pop is requested on a non-empty FIFO, the head must
    // match the oldest expected byte.
    always @(negedge clk) begin
        #3;
        if (rst_n && rd_en && !rx_empty) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedPop: got 0x%0h, expected no data", rd_data);
            end else begin
                checkOutput("popData", {24'h0, rd_data}, {24'h0, expQ.pop_front()});
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        rx           = 1'b1;
        rd_en        = 1'b0;
        err_clr      = 1'b0;
        clks_per_bit = 16'd16;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstRdData",   rd_data,   0);
        checkOutput("rstEmpty",    rx_empty,  1);
        checkOutput("rstFull",     rx_full,   0);
        checkOutput("rstCount",    count,     0);
        checkOutput("rstFrameErr", frame_err, 0);
        checkOutput("rstOverrun",  overrun,   0);
        checkOutput("rstIrq",      irq,       0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single byte 0x3D");
        expQ.push_back(8'h3D);
        applyStimulus(8'h3D, 1'b1, 1'b0);
        #1;
        checkOutput("oneCount",  count,    1);
        checkOutput("oneEmpty",  rx_empty, 0);
        checkOutput("oneData",   rd_data,  8'h3D);
        checkOutput("oneIrq",    irq,      1);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        checkOutput("popEmpty",  rx_empty, 1);
        checkOutput("popCount",  count,    0);
        checkOutput("popData0",  rd_data,  0);
        checkOutput("irqLag",    irq,      1);
        @(negedge clk);
        #1;
        checkOutput("irqClear",  irq,      0);

        $display("[TB] start-bit glitch");
        @(negedge clk);
        clks_per_bit = 16'd32;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        clks_per_bit = 16'd16;
        #1;
        checkOutput("glitchCount",    count,     0);
        checkOutput("glitchFrameErr", frame_err, 0);
        checkOutput("glitchIrq",      irq,       0);

        $display("[TB] framing error and break");
        applyStimulus(8'h55, 1'b0, 1'b0);
        repeat (3 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("ferrFlag",  frame_err, 1);
        checkOutput("ferrCount", count,     0);
        checkOutput("ferrIrq",   irq,       1);
        pulseErrClr();
        checkOutput("ferrClear", frame_err, 0);
        @(negedge clk);
        #1;
        checkOutput("ferrIrqClear", irq, 0);

        $display("[TB] overrun with nine bytes");
        for (int b = 1; b <= 9; b++) begin
            if (b <= FIFO_DEPTH) expQ.push_back(8'(b));
            applyStimulus(8'(b), 1'b1, 1'b0);
        end
        #1;
        checkOutput("ovrFull",    rx_full, 1);
        checkOutput("ovrCount",   count,   8);
        checkOutput("ovrFlag",    overrun, 1);
        checkOutput("ovrHead",    rd_data, 8'h01);
        @(negedge clk);
        rd_en = 1'b1;
        repeat (FIFO_DEPTH) @(negedge clk);
        rd_en = 1'b0;
        #1;
        checkOutput("drainEmpty", rx_empty, 1);
        checkOutput("drainCount", count,    0);
        pulseErrClr();
        checkOutput("ovrClear",   overrun,  0);

        $display("[TB] push and pop in the same cycle while full");
        for (int b = 1; b <= FIFO_DEPTH; b++) begin
            expQ.push_back(8'(b));
            applyStimulus(8'(b), 1'b1, 1'b0);
        end
        #1;
        checkOutput("fullBefore", rx_full, 1);
        expQ.push_back(8'h09);
        applyStimulus(8'h09, 1'b1, 1'b1);
        #1;
        checkOutput("simulCount",   count,   8);
        checkOutput("simulOverrun", overrun, 0);
        checkOutput("simulHead",    rd_data, 8'h02);
        checkOutput("simulFull",    rx_full, 1);
        @(negedge clk);
        rd_en = 1'b1;
        repeat (FIFO_DEPTH) @(negedge clk);
        rd_en = 1'b0;
        #1;
        checkOutput("simulDrained", count, 0);

        $display("[TB] reset in the middle of a frame");
        expQ.push_back(8'h77);
        applyStimulus(8'h77, 1'b1, 1'b0);
        #1;
        checkOutput("preRstCount", count, 1);
        @(negedge clk);
        fork
            applyStimulus(8'hA5, 1'b1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                expQ.delete();
                #1;
                checkOutput("midRstRdData", rd_data,   0);
                checkOutput("midRstEmpty",  rx_empty,  1);
                checkOutput("midRstFull",   rx_full,   0);
                checkOutput("midRstCount",  count,     0);
                checkOutput("midRstFerr",   frame_err, 0);
                checkOutput("midRstOvr",    overrun,   0);
                checkOutput("midRstIrq",    irq,       0);
                repeat (90) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        #1;
        checkOutput("abortCount", count,     0);
        checkOutput("abortFerr",  frame_err, 0);
        expQ.push_back(8'h3C);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        #1;
        checkOutput("afterRstCount", count,   1);
        checkOutput("afterRstData",  rd_data, 8'h3C);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("finalEmpty", rx_empty, 1);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
